axis_rr_arbiter: RTL and testbench

Round-robin AXI-Stream arbiter that shares one downstream sink between NUM_PORTS packetised source streams. Typical use: several per-channel sample streams, each already merged into one word, share a single DMA writer. Grant is locked for a whole packet, from the first beat to the beat carrying tlast. The output is registered, and the index of the granted port is presented on m_axis_tuser so the sink can demultiplex.

---
 rtl/axis_rr_arbiter_pkg.sv | 27 ++
 rtl/axis_rr_arbiter_if.sv | 31 +++
 rtl/axis_rr_pick.sv | 37 +++
 rtl/axis_rr_arbiter.sv | 115 +++++++++++
 tb/tb_axis_rr_arbiter.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_rr_arbiter_pkg.sv
// Shared types and width helpers for the AXI-Stream round-robin arbiter.
// Holds the FSM state enum and the port-index width rule.
package axis_rr_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam int MIN_PORTS = 2;
    localparam int MAX_PORTS = 16;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Port index is never narrower than one bit
    function automatic int idx_w(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/axis_rr_arbiter_if.sv
// AXI-Stream bundle: N lanes of tdata/tvalid/tlast/tready plus a tuser field.
// The arbiter uses an N-lane copy on its input and a single lane on its output.
interface axis_rr_arbiter_if #(
    parameter int N  = 1,
    parameter int DW = 32,
    parameter int UW = 1
) ();

    logic [N*DW-1:0] tdata;
    logic [N-1:0]    tvalid;
    logic [N-1:0]    tlast;
    logic [N-1:0]    tready;
    logic [UW-1:0]   tuser;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        output tuser,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        input  tuser,
        output tready
    );

endinterface

// File: rtl/axis_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping at NUM_PORTS, via a double-width rotate and priority encode.
module axis_rr_pick #(
    parameter int NUM_PORTS = 4,
    parameter int IDX_W     = 2
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    output logic                 found,
    output logic [IDX_W-1:0]     idx
);

    logic [NUM_PORTS-1:0] w_rot;
    logic [IDX_W:0]       w_off;
    logic [IDX_W:0]       w_sum;

    assign w_rot = NUM_PORTS'({req, req} >> ptr);
    assign found = |req;

    // Downward scan leaves the lowest set offset in w_off
    always_comb begin
        w_off = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (w_rot[i]) w_off = (IDX_W + 1)'(i);
        end
    end

    assign w_sum = {1'b0, ptr} + w_off;

    always_comb begin
        idx = IDX_W'(w_sum);
        if (w_sum >= (IDX_W + 1)'(NUM_PORTS)) begin
            idx = IDX_W'(w_sum - (IDX_W + 1)'(NUM_PORTS));
        end
    end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-locked round-robin AXI-Stream arbiter with a registered output stage.
// The granted port index travels with each beat on m_axis.tuser.
module axis_rr_arbiter
    import axis_rr_arbiter_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic [NUM_PORTS-1:0] cfg_port_enable,
    axis_rr_arbiter_if.slave     s_axis,
    axis_rr_arbiter_if.master    m_axis,
    output logic                 sts_busy
);

    localparam int IDX_W = idx_w(NUM_PORTS);

    state_e                r_state;
    logic [IDX_W-1:0]      r_ptr;
    logic [IDX_W-1:0]      r_gnt_idx;
    logic                  r_busy;
    logic [DATA_WIDTH-1:0] r_m_tdata;
    logic                  r_m_tvalid;
    logic                  r_m_tlast;
    logic [IDX_W-1:0]      r_m_tuser;

    logic [NUM_PORTS-1:0]  w_req;
    logic                  w_found;
    logic [IDX_W-1:0]      w_pick;
    logic                  w_out_free;
    logic [NUM_PORTS-1:0]  w_tready;
    logic                  w_accept;
    logic                  w_in_last;
    logic [DATA_WIDTH-1:0] w_in_data;
    logic [IDX_W-1:0]      w_ptr_next;

    assign w_req = s_axis.tvalid & cfg_port_enable;

    axis_rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_pick (
        .req   (w_req),
        .ptr   (r_ptr),
        .found (w_found),
        .idx   (w_pick)
    );

    assign w_out_free = ~r_m_tvalid | m_axis.tready;

    always_comb begin
        w_tready = '0;
        if (r_state == GRANT) w_tready[r_gnt_idx] = w_out_free;
    end

    assign w_accept  = w_tready[r_gnt_idx] & s_axis.tvalid[r_gnt_idx];
    assign w_in_last = s_axis.tlast[r_gnt_idx];
    assign w_in_data = s_axis.tdata[r_gnt_idx*DATA_WIDTH +: DATA_WIDTH];

    // Wrap at NUM_PORTS, not at the power of two above it
    assign w_ptr_next = (r_gnt_idx == IDX_W'(NUM_PORTS - 1)) ?
                        '0 : r_gnt_idx + 1'b1;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_gnt_idx  <= '0;
            r_busy     <= 1'b0;
            r_m_tdata  <= '0;
            r_m_tvalid <= 1'b0;
            r_m_tlast  <= 1'b0;
            r_m_tuser  <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_gnt_idx <= w_pick;
                        r_state   <= GRANT;
                        r_busy    <= 1'b1;
                    end
                end
                GRANT: begin
                    if (w_accept && w_in_last) begin
                        r_ptr   <= w_ptr_next;
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase

            if (w_accept) begin
                r_m_tdata  <= w_in_data;
                r_m_tlast  <= w_in_last;
                r_m_tuser  <= r_gnt_idx;
                r_m_tvalid <= 1'b1;
            end else if (m_axis.tready) begin
                r_m_tvalid <= 1'b0;
            end
        end
    end

    assign s_axis.tready = w_tready;
    assign m_axis.tdata  = r_m_tdata;
    assign m_axis.tvalid = r_m_tvalid;
    assign m_axis.tlast  = r_m_tlast;
    assign m_axis.tuser  = r_m_tuser;
    assign sts_busy      = r_busy;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Bench for axis_rr_arbiter: per-cycle vector table plus scripted
// multi-cycle sequences driven from a small source/sink model.
module tb_axis_rr_arbiter;

    localparam int NP = 4;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NP-1:0] en;
    logic          sts_busy;

    axis_rr_arbiter_if #(.N(NP), .DW(DW), .UW(1)) s_if ();
    axis_rr_arbiter_if #(.N(1),  .DW(DW), .UW(2)) m_if ();

    axis_rr_arbiter #(
        .NUM_PORTS  (NP),
        .DATA_WIDTH (DW)
    ) dut (
        .aclk            (clk),
        .aresetn         (rst_n),
        .cfg_port_enable (en),
        .s_axis          (s_if.slave),
        .m_axis          (m_if.master),
        .sts_busy        (sts_busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]   en;
        logic [3:0]   vld;
        logic [3:0]   lst;
        logic [127:0] dat;
        logic [3:0]   e_trdy;
        logic         e_mv;
        logic [31:0]  e_md;
        logic         e_ml;
        logic [1:0]   e_mu;
        logic         e_bz;
        logic         chk_d;
    } vec_t;

    vec_t tbl[17];

    function automatic vec_t rw(
        input logic [3:0] e, input logic [3:0] v, input logic [3:0] l,
        input logic [127:0] d, input logic [3:0] tr, input logic mv,
        input logic [31:0] md, input logic ml, input logic [1:0] mu,
        input logic bz);
        vec_t r;
        r.en = e; r.vld = v; r.lst = l; r.dat = d;
        r.e_trdy = tr; r.e_mv = mv; r.e_md = md; r.e_ml = ml;
        r.e_mu = mu; r.e_bz = bz; r.chk_d = mv;
        return r;
    endfunction

    function automatic logic [127:0] on2(input logic [31:0] x);
        return {32'h0, x, 64'h0};
    endfunction

    // Source model: per-port packet length, beat, packet number, count left
    int         s_len[NP];
    int         s_beat[NP];
    int         s_pkt[NP];
    int         s_pkts[NP];
    bit         s_stall[NP];
    logic       mrdy;
    int         cyc = 0;
    logic [31:0] lg_d[$];
    logic [1:0]  lg_u[$];
    logic        lg_l[$];
    int          lg_c[$];
    logic        p_mv, p_mr, p_ml;
    logic [31:0] p_md;
    logic [1:0]  p_mu;

    function automatic logic [31:0] mk(input int p, input int k, input int b);
        return 32'((p << 16) | (k << 8) | b);
    endfunction

    task automatic src_clear();
        for (int p = 0; p < NP; p++) begin
            s_len[p] = 1; s_beat[p] = 0; s_pkt[p] = 0;
            s_pkts[p] = 0; s_stall[p] = 1'b0;
        end
        lg_d.delete(); lg_u.delete(); lg_l.delete(); lg_c.delete();
        p_mv = 1'b0; p_mr = 1'b1; p_ml = 1'b0; p_md = '0; p_mu = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        en = '1;
        s_if.tvalid = '0;
        s_if.tlast = '0;
        s_if.tdata = '0;
        m_if.tready = 1'b1;
        mrdy = 1'b1;
        src_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_cycle();
        logic [3:0] tr;
        @(negedge clk);
        for (int p = 0; p < NP; p++) begin
            s_if.tvalid[p] = (s_pkts[p] > 0) && !s_stall[p];
            s_if.tlast[p] = (s_beat[p] == s_len[p] - 1);
            s_if.tdata[p*DW +: DW] = mk(p, s_pkt[p], s_beat[p]);
        end
        m_if.tready = mrdy;
        #1;
        tr = s_if.tready;
        chk("onehot_rdy", 32'($onehot0(tr)), 1);
        if (m_if.tvalid && !m_if.tready) chk("stall_rdy", tr, 0);
        if (p_mv && !p_mr) begin
            chk("hold_d", m_if.tdata, p_md);
            chk("hold_vlu", {m_if.tvalid, m_if.tlast, m_if.tuser},
                {1'b1, p_ml, p_mu});
        end
        if (m_if.tvalid && m_if.tready) begin
            lg_d.push_back(m_if.tdata);
            lg_u.push_back(m_if.tuser);
            lg_l.push_back(m_if.tlast);
            lg_c.push_back(cyc);
        end
        p_mv = m_if.tvalid; p_mr = m_if.tready; p_ml = m_if.tlast;
        p_md = m_if.tdata; p_mu = m_if.tuser;
        for (int p = 0; p < NP; p++) begin
            if (tr[p] && s_if.tvalid[p]) begin
                s_beat[p]++;
                if (s_beat[p] == s_len[p]) begin
                    s_beat[p] = 0; s_pkt[p]++; s_pkts[p]--;
                end
            end
        end
        cyc++;
    endtask

    initial begin
        int c0;
        int st;
        logic [3:0] pat;

        // Single port 2 packet A0..A3, then masking with enable 1010
        tbl[0]  = rw(4'hF, 4'h0, 4'h0, '0,           4'h0, 0, 32'h0,  0, 2'd0, 0);
        tbl[1]  = rw(4'hF, 4'h4, 4'h0, on2(32'hA0),  4'h0, 0, 32'h0,  0, 2'd0, 0);
        tbl[2]  = rw(4'hF, 4'h4, 4'h0, on2(32'hA0),  4'h4, 0, 32'h0,  0, 2'd0, 1);
        tbl[3]  = rw(4'hF, 4'h4, 4'h0, on2(32'hA1),  4'h4, 1, 32'hA0, 0, 2'd2, 1);
        tbl[4]  = rw(4'hF, 4'h4, 4'h0, on2(32'hA2),  4'h4, 1, 32'hA1, 0, 2'd2, 1);
        tbl[5]  = rw(4'hF, 4'h4, 4'h4, on2(32'hA3),  4'h4, 1, 32'hA2, 0, 2'd2, 1);
        tbl[6]  = rw(4'hF, 4'h0, 4'h0, '0,           4'h0, 1, 32'hA3, 1, 2'd2, 0);
        tbl[7]  = rw(4'hF, 4'h0, 4'h0, '0,           4'h0, 0, 32'h0,  0, 2'd0, 0);
        for (int i = 8; i < 16; i++) begin
            tbl[i] = rw(4'hA, 4'hF, 4'hF,
                        {32'hB3, 32'hB2, 32'hB1, 32'hB0},
                        4'h0, 0, 32'h0, 0, 2'd0, 0);
        end
        tbl[9].e_trdy  = 4'h8; tbl[9].e_bz  = 1'b1;
        tbl[11].e_trdy = 4'h2; tbl[11].e_bz = 1'b1;
        tbl[13].e_trdy = 4'h8; tbl[13].e_bz = 1'b1;
        tbl[15].e_trdy = 4'h2; tbl[15].e_bz = 1'b1;
        for (int i = 10; i <= 14; i += 4) begin
            tbl[i].e_mv = 1'b1; tbl[i].e_md = 32'hB3; tbl[i].e_ml = 1'b1;
            tbl[i].e_mu = 2'd3; tbl[i].chk_d = 1'b1;
        end
        tbl[12].e_mv = 1'b1; tbl[12].e_md = 32'hB1; tbl[12].e_ml = 1'b1;
        tbl[12].e_mu = 2'd1; tbl[12].chk_d = 1'b1;
        tbl[16] = rw(4'hF, 4'h0, 4'h0, '0, 4'h0, 1, 32'hB1, 1, 2'd1, 0);
        tbl[0].chk_d = 1'b1;

        s_if.tuser = '0;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            en = tbl[i].en;
            s_if.tvalid = tbl[i].vld;
            s_if.tlast = tbl[i].lst;
            s_if.tdata = tbl[i].dat;
            m_if.tready = 1'b1;
            #1;
            chk($sformatf("r%0d trdy", i), s_if.tready, tbl[i].e_trdy);
            chk($sformatf("r%0d mvalid", i), m_if.tvalid, tbl[i].e_mv);
            chk($sformatf("r%0d busy", i), sts_busy, tbl[i].e_bz);
            if (tbl[i].chk_d) begin
                chk($sformatf("r%0d mdata", i), m_if.tdata, tbl[i].e_md);
                chk($sformatf("r%0d mlast", i), m_if.tlast, tbl[i].e_ml);
                chk($sformatf("r%0d muser", i), m_if.tuser, tbl[i].e_mu);
            end
        end

        // Fairness: all ports, two 2-beat packets each
        do_reset();
        for (int p = 0; p < NP; p++) begin
            s_len[p] = 2; s_pkts[p] = 2;
        end
        c0 = cyc;
        repeat (30) run_cycle();
        chk("fair_n", lg_d.size(), 16);
        for (int i = 0; i < 16 && i < lg_d.size(); i++) begin
            chk($sformatf("fair%0d user", i), lg_u[i], (i / 2) % 4);
            chk($sformatf("fair%0d data", i), lg_d[i],
                mk((i / 2) % 4, i / 8, i % 2));
            chk($sformatf("fair%0d last", i), lg_l[i], i % 2);
            if (i == 0) chk("fair latency", lg_c[0] - c0, 2);
            else chk($sformatf("fair%0d gap", i), lg_c[i] - lg_c[i-1],
                     (i % 2 == 1) ? 1 : 2);
        end

        // Backpressure: sink ready pattern 1,0,0,1 during a 5-beat packet
        do_reset();
        s_len[1] = 5; s_pkts[1] = 1;
        pat = 4'b1001;
        for (int i = 0; i < 30; i++) begin
            mrdy = pat[3 - (i % 4)];
            run_cycle();
        end
        chk("bp_n", lg_d.size(), 5);
        for (int i = 0; i < 5 && i < lg_d.size(); i++) begin
            chk($sformatf("bp%0d data", i), lg_d[i], mk(1, 0, i));
            chk($sformatf("bp%0d user", i), lg_u[i], 1);
            chk($sformatf("bp%0d last", i), lg_l[i], (i == 4) ? 1 : 0);
        end

        // Mid-packet valid drop and enable clear on port 0, port 3 waiting
        do_reset();
        s_len[0] = 4; s_pkts[0] = 1;
        s_len[3] = 1; s_pkts[3] = 1;
        st = 0;
        for (int i = 0; i < 25; i++) begin
            s_stall[0] = (s_beat[0] == 2) && (st < 3);
            if (s_stall[0]) st++;
            if (s_beat[0] >= 2) en[0] = 1'b0;
            run_cycle();
            if (s_stall[0]) begin
                chk("mid busy", sts_busy, 1);
                chk("mid rdy3", s_if.tready[3], 0);
            end
        end
        chk("mid_n", lg_d.size(), 5);
        for (int i = 0; i < 5 && i < lg_d.size(); i++) begin
            chk($sformatf("mid%0d user", i), lg_u[i], (i == 4) ? 3 : 0);
            chk($sformatf("mid%0d data", i), lg_d[i],
                (i == 4) ? mk(3, 0, 0) : mk(0, 0, i));
            chk($sformatf("mid%0d last", i), lg_l[i],
                (i >= 3) ? 1 : 0);
        end

        // Reset mid-packet: move ptr to 1, interrupt a port 1 packet
        do_reset();
        s_len[0] = 1; s_pkts[0] = 1;
        repeat (5) run_cycle();
        s_len[1] = 4; s_pkts[1] = 1;
        repeat (4) run_cycle();
        chk("pre_rst busy", sts_busy, 1);
        chk("pre_rst mvalid", m_if.tvalid, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst trdy", s_if.tready, 0);
        chk("rst mvalid", m_if.tvalid, 0);
        chk("rst mdata", m_if.tdata, 0);
        chk("rst mlast", m_if.tlast, 0);
        chk("rst muser", m_if.tuser, 0);
        chk("rst busy", sts_busy, 0);
        src_clear();
        s_if.tvalid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        s_len[0] = 1; s_pkts[0] = 1;
        s_len[1] = 1; s_pkts[1] = 1;
        repeat (10) run_cycle();
        chk("post_rst n", lg_d.size(), 2);
        if (lg_u.size() >= 2) begin
            chk("post_rst first", lg_u[0], 0);
            chk("post_rst second", lg_u[1], 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
